pll_reset_sequencer: RTL

Controller for the board PLL clock-generation block (PLL_BASE plus BUFG-buffered outputs). It drives the PLL reset, waits for a stable lock, then releases downstream synchronous resets in a fixed staggered order. Lock loss while running, or a software relock request, restarts the whole sequence. It sits at the top level, clocked from the raw board clock, between the PLL primitive and the video/CPU/sound reset trees.

---
 rtl/pll_seq_pkg.sv | 27 ++
 rtl/pll_lock_sync.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: FSM state encoding,
// default timing constants and the width of the saturating retry counter.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } pll_state_e;

   localparam int unsigned DEF_RST_HOLD_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT       = 4096;
   localparam int unsigned DEF_LOCK_STABLE_CYCLES = 64;
   localparam int unsigned DEF_NUM_STAGES         = 3;
   localparam int unsigned DEF_STAGGER_CYCLES     = 8;
   localparam int unsigned DEF_MAX_RETRIES        = 4;

   localparam int unsigned RETRY_W = 8;

   function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCKED flag into the
// board clock domain; both flops reset to 0 (treated as "not locked").
module pll_lock_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: pulses PLL reset, waits for a stable lock, then
// releases downstream resets in staggered order. Optional retry limit with
// FAULT state is enabled by defining PLL_RETRY_LIMIT_EN.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
   parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
   parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned NUM_STAGES         = DEF_NUM_STAGES,
   parameter int unsigned STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
   parameter int unsigned MAX_RETRIES        = DEF_MAX_RETRIES
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pll_locked,
   input  logic                  force_relock,
   output logic                  pll_rst,
   output logic [NUM_STAGES-1:0] stage_reset_n,
   output logic                  ready,
   output logic                  lock_lost,
   output logic [RETRY_W-1:0]    retry_count,
   output logic                  fault
);

   localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned STAG_W = $clog2(STAGGER_CYCLES + 1);

   localparam logic [HOLD_W-1:0]     HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [TMO_W-1:0]      TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STAB_W-1:0]     STAB_LAST   = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [STAG_W-1:0]     STAG_LAST   = STAG_W'(STAGGER_CYCLES - 1);
   localparam logic [NUM_STAGES-1:0] STAGE_FIRST = NUM_STAGES'(1);

   if (RST_HOLD_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE_CYCLES < 1 ||
       NUM_STAGES < 1 || STAGGER_CYCLES < 1 || MAX_RETRIES < 1) begin : g_param_check
      $error("pll_reset_sequencer: all cycle/count parameters must be >= 1");
   end

   pll_state_e              state_q, state_d;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic [STAB_W-1:0]       stab_q, stab_d;
   logic [STAG_W-1:0]       rel_q, rel_d;
   logic [NUM_STAGES-1:0]   stage_q, stage_d;
   logic                    lock_lost_q, lock_lost_d;
   logic [RETRY_W-1:0]      retry_q, retry_d;
   logic                    locked_s;

`ifdef PLL_RETRY_LIMIT_EN
   localparam int unsigned   CONS_W    = $clog2(MAX_RETRIES + 1);
   localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(MAX_RETRIES - 1);
   logic [CONS_W-1:0]        consec_q, consec_d;
`endif

   pll_lock_sync u_lock_sync (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .async_i (pll_locked),
      .sync_o  (locked_s)
   );

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      tmo_d       = tmo_q;
      stab_d      = stab_q;
      rel_d       = rel_q;
      stage_d     = stage_q;
      lock_lost_d = 1'b0;
      retry_d     = retry_q;
`ifdef PLL_RETRY_LIMIT_EN
      consec_d    = consec_q;
`endif

      if (force_relock) begin
         // Software relock wins over every other transition and also leaves FAULT.
         state_d = RESET_PLL;
         hold_d  = '0;
         stage_d = '0;
`ifdef PLL_RETRY_LIMIT_EN
         if (state_q == FAULT) consec_d = '0;
`endif
      end else begin
         case (state_q)
            RESET_PLL: begin
               tmo_d   = '0;
               stage_d = '0;
               if (hold_q == HOLD_LAST) state_d = WAIT_LOCK;
               else                     hold_d  = hold_q + 1'b1;
            end

            WAIT_LOCK, STABLE: begin
               // One timeout window spans both states; glitches back to WAIT_LOCK keep it running.
               if (tmo_q == TMO_LAST) begin
                  state_d = RESET_PLL;
                  hold_d  = '0;
                  stage_d = '0;
                  retry_d = sat_inc(retry_q);
`ifdef PLL_RETRY_LIMIT_EN
                  consec_d = consec_q + 1'b1;
                  if (consec_q == CONS_LAST) state_d = FAULT;
`endif
               end else begin
                  tmo_d = tmo_q + 1'b1;
                  if (!locked_s) begin
                     state_d = WAIT_LOCK;
                  end else if (state_q == WAIT_LOCK) begin
                     state_d = STABLE;
                     stab_d  = '0;
                  end else if (stab_q == STAB_LAST) begin
                     state_d = RELEASE;
                     stage_d = STAGE_FIRST;
                     rel_d   = '0;
                  end else begin
                     stab_d = stab_q + 1'b1;
                  end
               end
            end

            RELEASE, RUN: begin
               if (!locked_s) begin
                  state_d     = RESET_PLL;
                  hold_d      = '0;
                  stage_d     = '0;
                  lock_lost_d = 1'b1;
               end else if (state_q == RELEASE) begin
                  if (&stage_q) begin
                     state_d = RUN;
`ifdef PLL_RETRY_LIMIT_EN
                     consec_d = '0;
`endif
                  end else if (rel_q == STAG_LAST) begin
                     stage_d = (stage_q << 1) | STAGE_FIRST;
                     rel_d   = '0;
                  end else begin
                     rel_d = rel_q + 1'b1;
                  end
               end
            end

`ifdef PLL_RETRY_LIMIT_EN
            FAULT: begin
               stage_d = '0;
            end
`endif

            default: begin
               state_d = RESET_PLL;
               hold_d  = '0;
               stage_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RESET_PLL;
         hold_q      <= '0;
         tmo_q       <= '0;
         stab_q      <= '0;
         rel_q       <= '0;
         stage_q     <= '0;
         lock_lost_q <= 1'b0;
         retry_q     <= '0;
`ifdef PLL_RETRY_LIMIT_EN
         consec_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         tmo_q       <= tmo_d;
         stab_q      <= stab_d;
         rel_q       <= rel_d;
         stage_q     <= stage_d;
         lock_lost_q <= lock_lost_d;
         retry_q     <= retry_d;
`ifdef PLL_RETRY_LIMIT_EN
         consec_q    <= consec_d;
`endif
      end
   end

   assign pll_rst       = (state_q == RESET_PLL) || (state_q == FAULT);
   assign ready         = (state_q == RUN);
   assign stage_reset_n = stage_q;
   assign lock_lost     = lock_lost_q;
   assign retry_count   = retry_q;

`ifdef PLL_RETRY_LIMIT_EN
   assign fault = (state_q == FAULT);
`else
   assign fault = 1'b0;
`endif

endmodule
